seq_alu: RTL and testbench

- Parametrised, registered successor to the single-cycle datapath ALU.
- Keeps the existing Control encodings and adds iterative unsigned multiply, divide and remainder.
- Uses a valid/ready handshake so a multi-cycle execute stage can stall the pipeline.
- Sits in the EX stage between the operand muxes and the EX/MEM register.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/seq_alu_if.sv | 28 ++
 rtl/seq_alu_muldiv.sv | 84 ++++++++
 rtl/seq_alu.sv | 104 ++++++++++
 tb/tb_seq_alu.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode values, FSM states and
// the multi-cycle opcode classifier.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_MULU = 4'd8;
  localparam logic [3:0] OP_DIVU = 4'd9;
  localparam logic [3:0] OP_REMU = 4'd10;
  localparam logic [3:0] OP_NOR  = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MULU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle of the sequential ALU.
//   in_valid/in_ready/control/input1/input2 : request handshake and operands
//   out_valid/out_ready/out/zero/illegal    : response handshake and result
// master = requester (operand muxes), slave = the ALU.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       control;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             illegal;

  modport master (
    output in_valid, control, input1, input2, out_ready,
    input  in_ready, out_valid, out, zero, illegal
  );

  modport slave (
    input  in_valid, control, input1, input2, out_ready,
    output in_ready, out_valid, out, zero, illegal
  );
endinterface

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned multiply / divide / remainder datapath.
//   clk, rst_n : clock, async active-low reset
//   start      : load operands a/b and opcode op, begin WIDTH iterations
//   done       : high in the cycle of the final iteration
//   result     : valid while done (post-final-iteration value)
module seq_alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  // acc : product accumulator (MULU) or partial remainder (DIVU/REMU)
  // opa : multiplier shifted right, or dividend shifting into quotient
  // opb : multiplicand shifted left, or divisor
  logic             busy;
  logic             is_mul;
  logic             is_rem;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;

  logic [WIDTH-1:0] mul_acc_nx;
  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;

  always_comb begin
    mul_acc_nx = opa[0] ? (acc + opb) : acc;
    // Restoring step: bring in the next dividend bit, subtract if it fits.
    // A zero divisor always fits, giving an all-ones quotient and the
    // dividend as remainder.
    trial  = {acc, opa[WIDTH-1]};
    ge     = (trial >= {1'b0, opb});
    rem_nx = ge ? (trial[WIDTH-1:0] - opb) : trial[WIDTH-1:0];
    quo_nx = {opa[WIDTH-2:0], ge};
  end

  assign done   = busy && (cnt == CNT_W'(1));
  assign result = is_mul ? mul_acc_nx : (is_rem ? rem_nx : quo_nx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      is_mul <= 1'b0;
      is_rem <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      opa    <= '0;
      opb    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      is_mul <= (op == OP_MULU);
      is_rem <= (op == OP_REMU);
      cnt    <= CNT_W'(WIDTH);
      acc    <= '0;
      opa    <= a;
      opb    <= b;
    end else if (busy) begin
      cnt <= cnt - CNT_W'(1);
      if (is_mul) begin
        acc <= mul_acc_nx;
        opa <= opa >> 1;
        opb <= opb << 1;
      end else begin
        acc <= rem_nx;
        opa <= quo_nx;
      end
      if (cnt == CNT_W'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered EX-stage ALU with valid/ready handshake.
//   clk, rst_n : clock, async active-low reset
//   bus        : seq_alu_if slave (request, operands, result, zero, illegal)
// Single-cycle ops complete one cycle after accept; MULU/DIVU/REMU run
// WIDTH iterations in seq_alu_muldiv and complete WIDTH+1 cycles after accept.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_alu_if.slave bus
);

  state_t           state;
  logic [WIDTH-1:0] out_q;
  logic             zero_q;
  logic             illegal_q;

  logic             accept;
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_result;
  logic [WIDTH-1:0] simple_res;
  logic             simple_ill;

  assign bus.in_ready  = (state == S_IDLE) || ((state == S_DONE) && bus.out_ready);
  assign bus.out_valid = (state == S_DONE);
  assign bus.out       = out_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign md_start = accept && is_multicycle(bus.control);

  always_comb begin
    simple_res = '0;
    simple_ill = 1'b0;
    case (bus.control)
      OP_AND: simple_res = bus.input1 & bus.input2;
      OP_OR:  simple_res = bus.input1 | bus.input2;
      OP_ADD: simple_res = bus.input1 + bus.input2;
      OP_SUB: simple_res = bus.input1 - bus.input2;
      OP_SLT: simple_res = {{(WIDTH-1){1'b0}}, (bus.input1 < bus.input2)};
      OP_NOR: simple_res = ~(bus.input1 | bus.input2);
      default: begin
        simple_res = '1;
        simple_ill = 1'b1;
      end
    endcase
  end

  seq_alu_muldiv #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .op     (bus.control),
    .a      (bus.input1),
    .b      (bus.input2),
    .done   (md_done),
    .result (md_result)
  );

  // Acceptance is handled ahead of the per-state logic: it can only occur
  // in IDLE or in DONE with out_ready, and both paths behave identically.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      out_q     <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else if (accept) begin
      if (is_multicycle(bus.control)) begin
        state     <= S_BUSY;
        illegal_q <= 1'b0;
      end else begin
        state     <= S_DONE;
        out_q     <= simple_res;
        zero_q    <= (simple_res == '0);
        illegal_q <= simple_ill;
      end
    end else begin
      case (state)
        S_BUSY: begin
          if (md_done) begin
            state  <= S_DONE;
            out_q  <= md_result;
            zero_q <= (md_result == '0);
          end
        end
        S_DONE: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=32 and WIDTH=8 instances)
// with a queue scoreboard of expected results.
module tb_seq_alu;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] out;
    logic        zero;
    logic        illegal;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  seq_alu_if #(.WIDTH(32)) b32 ();
  seq_alu_if #(.WIDTH(8))  b8 ();

  seq_alu #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
  seq_alu #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    p         = 64'(a) * 64'(b);
    e.illegal = 1'b0;
    case (op)
      4'd0:    e.out = a & b;
      4'd1:    e.out = a | b;
      4'd2:    e.out = a + b;
      4'd6:    e.out = a - b;
      4'd7:    e.out = (a < b) ? 32'd1 : 32'd0;
      4'd12:   e.out = ~(a | b);
      4'd8:    e.out = p[31:0];
      4'd9:    e.out = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd10:   e.out = (b == 0) ? a : a % b;
      default: begin
        e.out     = 32'hFFFF_FFFF;
        e.illegal = 1'b1;
      end
    endcase
    e.zero = (e.out == 0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    b32.in_valid = 1'b1;
    b32.control  = op;
    b32.input1   = a;
    b32.input2   = b;
    while (!b32.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_in_ready", 32'(b32.in_ready), 32'd1);
    sb.push_back(model(op, a, b));
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
  endtask

  task automatic receive(input string tag, input int exp_lat);
    int   lat = 1;
    exp_t e;
    while (!b32.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_valid"}, 32'(b32.out_valid), 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_out"}, b32.out, e.out);
      chk({tag, "_zero"}, 32'(b32.zero), 32'(e.zero));
      chk({tag, "_illegal"}, 32'(b32.illegal), 32'(e.illegal));
    end
  endtask

  initial begin
    int   lat;
    exp_t e;

    rst_n         = 1'b0;
    b32.in_valid  = 1'b0;
    b32.control   = 4'd0;
    b32.input1    = '0;
    b32.input2    = '0;
    b32.out_ready = 1'b1;
    b8.in_valid   = 1'b0;
    b8.control    = 4'd0;
    b8.input1     = '0;
    b8.input2     = '0;
    b8.out_ready  = 1'b1;

    // Reset values
    @(posedge clk); #1;
    chk("rst_out", b32.out, 32'd0);
    chk("rst_zero", 32'(b32.zero), 32'd1);
    chk("rst_illegal", 32'(b32.illegal), 32'd0);
    chk("rst_out_valid", 32'(b32.out_valid), 32'd0);
    chk("rst_in_ready", 32'(b32.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-cycle ops, back-to-back
    send(OP_ADD, 32'd5, 32'd7);                  receive("add", 1);
    send(OP_SUB, 32'd3, 32'd3);                  receive("sub_zero", 1);
    send(OP_ADD, 32'hFFFF_FFFF, 32'd1);          receive("add_wrap", 1);
    send(OP_SLT, 32'd2, 32'd9);                  receive("slt", 1);
    send(OP_SLT, 32'd9, 32'd2);                  receive("slt_false", 1);
    send(OP_NOR, 32'd0, 32'd0);                  receive("nor", 1);
    send(4'd5, 32'd1, 32'd2);                    receive("illegal5", 1);
    send(OP_OR, 32'h0F00_0000, 32'h0000_00F0);   receive("or_clr_ill", 1);

    // MULU with operand scrambling during BUSY, then backpressure
    @(posedge clk); #1;
    b32.out_ready = 1'b0;
    send(OP_MULU, 32'h0001_0000, 32'h0001_0003);
    lat = 1;
    while (!b32.out_valid && lat < 100) begin
      chk("mul_busy_in_ready", 32'(b32.in_ready), 32'd0);
      b32.input1  = $urandom;
      b32.input2  = $urandom;
      b32.control = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
      lat++;
    end
    chk("mul_lat", 32'(lat), 32'd33);
    e = sb.pop_front();
    chk("mul_out", b32.out, e.out);
    chk("mul_out_const", b32.out, 32'h0003_0000);
    chk("mul_illegal", 32'(b32.illegal), 32'd0);

    b32.in_valid = 1'b1;
    b32.control  = OP_AND;
    b32.input1   = 32'hF0;
    b32.input2   = 32'h3C;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out", b32.out, 32'h0003_0000);
      chk("bp_zero", 32'(b32.zero), 32'd0);
      chk("bp_out_valid", 32'(b32.out_valid), 32'd1);
      chk("bp_in_ready", 32'(b32.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    b32.out_ready = 1'b1;
    sb.push_back(model(OP_AND, 32'hF0, 32'h3C));
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    receive("and_b2b", 1);
    chk("and_const", b32.out, 32'h30);

    // Divide / remainder including divide by zero
    send(OP_DIVU, 32'd100, 32'd7);               receive("divu", 33);
    send(OP_REMU, 32'd100, 32'd7);               receive("remu", 33);
    send(OP_DIVU, 32'd100, 32'd0);               receive("divu_by0", 33);
    send(OP_REMU, 32'd100, 32'd0);               receive("remu_by0", 33);
    send(OP_DIVU, 32'hFFFF_FFFF, 32'h0001_0001); receive("divu_big", 33);
    send(4'd15, 32'd0, 32'd0);                   receive("illegal15", 1);
    send(OP_MULU, 32'hDEAD_BEEF, 32'h1234_5677); receive("mulu_rand", 33);

    // Reset abort during DIVU
    send(OP_DIVU, 32'd1000, 32'd3);
    void'(sb.pop_back());
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(b32.out_valid), 32'd0);
    chk("abort_out", b32.out, 32'd0);
    chk("abort_zero", 32'(b32.zero), 32'd1);
    chk("abort_in_ready", 32'(b32.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_still_idle", 32'(b32.out_valid), 32'd0);
    send(OP_ADD, 32'd40, 32'd2);                 receive("add_after_abort", 1);

    // WIDTH=8 instance: MULU 15*17
    b8.in_valid = 1'b1;
    b8.control  = OP_MULU;
    b8.input1   = 8'd15;
    b8.input2   = 8'd17;
    chk("w8_in_ready", 32'(b8.in_ready), 32'd1);
    sb.push_back('{out: 32'hFF, zero: 1'b0, illegal: 1'b0});
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    b8.input1   = 8'd3;
    b8.input2   = 8'd3;
    lat = 1;
    while (!b8.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w8_lat", 32'(lat), 32'd9);
    e = sb.pop_front();
    chk("w8_out", 32'(b8.out), e.out);
    chk("w8_zero", 32'(b8.zero), 32'(e.zero));
    chk("w8_illegal", 32'(b8.illegal), 32'(e.illegal));

    @(posedge clk); #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
